// File: rtl/sa_ctrl_pkg.sv
// Shared types and constants for the systolic-array controller (sa_ctrl).
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_W,
    ST_LOAD_W0,
    ST_LOAD_W1,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int PIPE_LAT_DEFAULT = 3;

  // c_sel fields: bit CSEL_ACC selects accumulate, bits 1:0 are the slot.
  localparam int         CSEL_ACC    = 2;
  localparam logic [2:0] CSEL_BUBBLE = 3'b100;

  typedef struct packed {
    logic       is_final;
    logic [2:0] c_sel;
  } tag_t;

  localparam int   TAG_W      = $bits(tag_t);
  localparam tag_t TAG_BUBBLE = '{is_final: 1'b0, c_sel: CSEL_BUBBLE};

  function automatic tag_t make_tag(logic accumulate, logic [1:0] slot, logic is_final);
    tag_t t;
    t.is_final = is_final;
    t.c_sel    = {accumulate, slot};
    return t;
  endfunction

endpackage

// File: rtl/sa_ctrl_delay.sv
// Fixed-depth shift register aligning beat tags {final, c_sel} with array data.
module sa_ctrl_delay
  import sa_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] din,
  output logic [TAG_W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_shift
    logic [TAG_W-1:0] sr [DEPTH];

    // NOTE: every stage is reset (not just the head) because each stage's
    // content reaches c_sel and must read as a harmless bubble after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= TAG_BUBBLE;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/sa_ctrl.sv
// 2x2 systolic-array job sequencer: weight load, skewed operand streaming,
// accumulator tagging. Optional perf counters when SA_CTRL_PERF_EN is defined.
module sa_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cfg_nvec,
  input  logic [3:0]  cfg_npass,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_data,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [15:0] a_data,
  output logic [7:0]  A_in_1,
  output logic [7:0]  A_in_2,
  output logic [7:0]  B_in_1,
  output logic [7:0]  B_in_2,
  output logic [1:0]  P2_en,
  output logic [2:0]  c_sel,
  output logic        busy,
  output logic        res_valid,
  output logic [1:0]  res_slot,
`ifdef SA_CTRL_PERF_EN
  output logic [15:0] perf_cycles,
  output logic [15:0] perf_stalls,
`endif
  output logic        done
);

  localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t          state, state_nxt;
  logic [1:0]      nvec_q, v_q;
  logic [3:0]      npass_q, p_q;
  logic [31:0]     w_q;
  logic [7:0]      skew_q;
  logic [DCW-1:0]  drain_cnt;
  logic            a_accept, last_vec;
  tag_t            tag_in, tag_out;

  assign a_accept = (state == ST_STREAM) && a_valid;
  assign last_vec = (v_q == nvec_q);

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    a_ready   = 1'b0;
    P2_en     = 2'b00;
    B_in_1    = 8'h00;
    B_in_2    = 8'h00;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    A_in_1    = a_accept ? a_data[7:0] : 8'h00;
    tag_in    = TAG_BUBBLE;
    if (a_accept) tag_in = make_tag(p_q != 4'd0, v_q, p_q == npass_q);

    unique case (state)
      ST_IDLE:    if (start) state_nxt = ST_WAIT_W;
      ST_WAIT_W: begin
        w_ready = 1'b1;
        if (w_valid) state_nxt = ST_LOAD_W0;
      end
      ST_LOAD_W0: begin
        P2_en     = 2'b11;
        B_in_1    = w_q[23:16];
        B_in_2    = w_q[31:24];
        state_nxt = ST_LOAD_W1;
      end
      ST_LOAD_W1: begin
        P2_en     = 2'b11;
        B_in_1    = w_q[7:0];
        B_in_2    = w_q[15:8];
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        a_ready = 1'b1;
        if (a_valid && last_vec) state_nxt = (p_q < npass_q) ? ST_WAIT_W : ST_DRAIN;
      end
      ST_DRAIN:   if (drain_cnt == DCW'(PIPE_LAT - 1)) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      nvec_q    <= '0;
      npass_q   <= '0;
      v_q       <= '0;
      p_q       <= '0;
      w_q       <= '0;
      skew_q    <= '0;
      drain_cnt <= '0;
      res_valid <= 1'b0;
      res_slot  <= '0;
    end else begin
      state     <= state_nxt;
      skew_q    <= a_accept ? a_data[15:8] : 8'h00;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DCW'(1) : '0;
      res_valid <= tag_out.is_final;
      res_slot  <= tag_out.c_sel[1:0];
      if (state == ST_IDLE && start) begin
        nvec_q  <= cfg_nvec;
        npass_q <= cfg_npass;
        v_q     <= '0;
        p_q     <= '0;
      end
      if (state == ST_WAIT_W && w_valid) w_q <= w_data;
      if (a_accept) begin
        v_q <= last_vec ? 2'd0 : v_q + 2'd1;
        if (last_vec && p_q < npass_q) p_q <= p_q + 4'd1;
      end
    end
  end

  sa_ctrl_delay #(.DEPTH(PIPE_LAT - 1)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign A_in_2 = skew_q;
  assign c_sel  = tag_out.c_sel;

`ifdef SA_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (state == ST_IDLE && start)) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
      if (state == ST_STREAM && !a_valid && perf_stalls != 16'hFFFF)
        perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter PIPE_LAT, default 3: cycles from a beat on A_in_1 to the accumulator update for that beat.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 cfg_nvec  input  2  vectors per pass minus 1 (1..4 vectors); captured on accepted start.
REQ-006 cfg_npass  input  4  passes minus 1 (1..16 passes); captured on accepted start.
REQ-007 w_valid / w_ready  input / output  1 / 1  weight beat handshake.
REQ-008 w_data  input  32  {row1_b2, row1_b1, row0_b2, row0_b1}, 8 bits each.
REQ-009 a_valid / a_ready  input / output  1 / 1  operand beat handshake.
REQ-010 a_data  input  16  {a_row1, a_row0}.
REQ-011 A_in_1, A_in_2, B_in_1, B_in_2  output  8 each  array operand drives.
REQ-012 P2_en  output  2  per-row B-load enable.
REQ-013 c_sel  output  3  accumulator control: bit2 = 0 clear-and-write / 1 accumulate; bits1:0 = slot.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 res_valid / res_slot  output  1 / 2  final-pass accumulator update for res_slot takes effect this cycle.
REQ-016 done  output  1  one-cycle pulse at job end.

Function
REQ-017 States: IDLE, WAIT_W, LOAD_W0, LOAD_W1, STREAM, DRAIN, DONE.
REQ-018 IDLE->WAIT_W on start; pass counter p=0, vector counter v=0.
REQ-019 WAIT_W: w_ready=1; on w_valid&w_ready, latch w_data, go to LOAD_W0.
REQ-020 LOAD_W0: B_in_1/B_in_2 = row1 weights, P2_en=2'b11; LOAD_W1: row0 weights, P2_en=2'b11; then STREAM.
REQ-021 P2_en=2'b00 and B_in_*=0 in all states other than LOAD_W0/LOAD_W1.
REQ-022 STREAM: a_ready=1; an accepted beat drives A_in_1=a_row0 in the same cycle and A_in_2=a_row1 one cycle later (row skew register).
REQ-023 Accepted beat tag: slot=v, mode bit = 0 if p==0 else 1; v increments, wrapping to 0 after cfg_nvec.
REQ-024 Bubble (a_valid=0 in STREAM): A_in_1=0 (skewed A_in_2=0 next cycle), tag c_sel=3'b100 (accumulate zero into slot 0, harmless).
REQ-025 Tag delayed PIPE_LAT-1 cycles before driving c_sel so it coincides with the data; outside STREAM/DRAIN the delay line is fed 3'b100.
REQ-026 After last vector of a pass: if p<cfg_npass, p++ and go to WAIT_W; else go to DRAIN.
REQ-027 Beats tagged in the final pass carry final=1; res_valid/res_slot emerge from the delay line PIPE_LAT cycles after beat acceptance.
REQ-028 DRAIN lasts exactly PIPE_LAT cycles, then DONE (done=1 one cycle), then IDLE.
REQ-029 start outside IDLE is ignored; cfg_* changes after capture have no effect.
REQ-030 w_ready=0 outside WAIT_W; a_ready=0 outside STREAM.
REQ-031 Counters are modulo; no overflow path exists given 2-bit v and 4-bit p.

Reset
REQ-032 rst returns to IDLE from any state in one cycle, flushing skew and delay registers.
REQ-033 Reset values: all data outputs 0, P2_en=0, c_sel=3'b100, busy/res_valid/done/w_ready/a_ready=0.

Configuration
REQ-034 SA_CTRL_PERF_EN defined: outputs perf_cycles[15:0] (counts busy cycles) and perf_stalls[15:0] (counts bubbles), both saturating at 16'hFFFF, cleared by rst and by accepted start.
REQ-035 SA_CTRL_PERF_EN undefined: those ports and counters are absent; all other behaviour identical.

Structure
REQ-036 Package sa_ctrl_pkg holds the state enum, c_sel field constants (CSEL_ACC bit, CSEL_BUBBLE=3'b100) and PIPE_LAT default.
REQ-037 Sub-module sa_ctrl_delay: parameterised-depth shift register carrying {final, c_sel}, reset to bubble value.

Verification
REQ-038 nvec=3, npass=0, a_valid always 1 -> c_sel sequence 000,001,010,011 starting PIPE_LAT-1 cycles after first beat; four res_valid slots 0..3; done once.
REQ-039 nvec=1, npass=2 -> three weight loads (P2_en=11 for two cycles each); pass0 c_sel bit2=0, passes1-2 bit2=1; res_valid only for pass 2.
REQ-040 a_valid low 2 cycles mid-pass -> two bubbles, c_sel=100 in those slots, perf_stalls=2 when PERF enabled.
REQ-041 a_data=16'h0201 -> A_in_1=8'h01 cycle t, A_in_2=8'h02 cycle t+1.
REQ-042 rst asserted in STREAM -> next cycle all outputs at reset values; subsequent start runs a clean job.
